// File: rtl/post_st_drain_pkg.sv
// Shared types for the post-commit store drain: FIFO entry layout and drain FSM states.
package post_st_drain_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MASK_W  = 4;
  localparam int unsigned BMASK_W = 4;

  // Entry held in post_st_fifo; bmask != 0 means the store is still under an unresolved branch.
  typedef struct packed {
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    wdata;
    logic [MASK_W-1:0]  wmask;
    logic [BMASK_W-1:0] bmask;
  } mem_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } st_drain_state_t;

  // Clear the byte offset so the request addresses the containing word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/post_st_drain.sv
// Drains non-speculative stores from the head of post_st_fifo into the dmem write port,
// one outstanding write at a time, with back-to-back issue on response.
module post_st_drain
  import post_st_drain_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  mem_pkt_t          fifo_out,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [MASK_W-1:0] dmem_wmask,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_resp,
  output logic              st_inflight,
  output logic [XLEN-1:0]   st_inflight_addr,
  output logic [CNT_W-1:0]  st_drained_cnt,
  output logic [CNT_W-1:0]  st_stall_cnt
);

  st_drain_state_t   r_state;
  st_drain_state_t   w_state_nxt;

  logic [XLEN-1:0]   r_dmem_addr;
  logic [MASK_W-1:0] r_dmem_wmask;
  logic [XLEN-1:0]   r_dmem_wdata;
  logic              r_inflight;
  logic [XLEN-1:0]   r_inflight_addr;
  logic [CNT_W-1:0]  r_drained_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_eligible;
  logic              w_pop;
  logic              w_clear;
  logic              w_done;
  logic              w_stall;
  logic [XLEN-1:0]   w_head_word_addr;

  // Head may leave the FIFO only when it is resolved; reset blocks any pop.
  assign w_eligible       = !rst && !fifo_empty && (fifo_out.bmask == '0);
  assign w_head_word_addr = word_align(fifo_out.addr);

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    w_done      = 1'b0;
    w_stall     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_eligible) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (r_dmem_wmask == '0) begin
          // Empty byte mask: nothing to write, retire immediately.
          w_done      = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (dmem_resp) begin
          w_done = 1'b1;
          if (w_eligible) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_clear     = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_stall     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the popped head into the request registers; hold them until retired.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dmem_addr     <= '0;
      r_dmem_wmask    <= '0;
      r_dmem_wdata    <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else if (w_pop) begin
      r_dmem_addr     <= w_head_word_addr;
      r_dmem_wmask    <= fifo_out.wmask;
      r_dmem_wdata    <= fifo_out.wdata;
      r_inflight      <= (fifo_out.wmask != '0);
      r_inflight_addr <= w_head_word_addr;
    end else if (w_clear) begin
      r_dmem_wmask    <= '0;
      r_inflight      <= 1'b0;
    end
  end

  // Saturating count of retired stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drained_cnt <= '0;
    end else if (w_done && (r_drained_cnt != '1)) begin
      r_drained_cnt <= r_drained_cnt + CNT_W'(1);
    end
  end

  // Saturating count of request cycles that saw no response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign fifo_ren         = w_pop;
  assign dmem_addr        = r_dmem_addr;
  assign dmem_wmask       = r_dmem_wmask;
  assign dmem_wdata       = r_dmem_wdata;
  assign st_inflight      = r_inflight;
  assign st_inflight_addr = r_inflight_addr;
  assign st_drained_cnt   = r_drained_cnt;
  assign st_stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_post_st_drain.sv
// Bench for post_st_drain: a queue-backed FIFO model feeds the head, a scoreboard
// holds expected dmem writes, and a monitor checks each completed write and request stability.
module tb_post_st_drain;
  import post_st_drain_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } wr_t;

  logic        clk;
  logic        rst;
  mem_pkt_t    fifo_out;
  logic        fifo_empty;
  logic        fifo_ren;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic        st_inflight;
  logic [31:0] st_inflight_addr;
  logic [31:0] st_drained_cnt;
  logic [31:0] st_stall_cnt;

  int checks = 0;
  int errors = 0;

  mem_pkt_t fq[$];
  wr_t      exp_q[$];
  logic     popped = 1'b0;

  post_st_drain #(.CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_out         (fifo_out),
    .fifo_empty       (fifo_empty),
    .fifo_ren         (fifo_ren),
    .dmem_addr        (dmem_addr),
    .dmem_wmask       (dmem_wmask),
    .dmem_wdata       (dmem_wdata),
    .dmem_resp        (dmem_resp),
    .st_inflight      (st_inflight),
    .st_inflight_addr (st_inflight_addr),
    .st_drained_cnt   (st_drained_cnt),
    .st_stall_cnt     (st_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Queue a FIFO entry; stores with a nonzero mask also expect a dmem write.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      input logic [3:0] b);
    mem_pkt_t p;
    wr_t      w;
    p.addr = a; p.wdata = d; p.wmask = m; p.bmask = b;
    fq.push_back(p);
    if (m != 4'b0000) begin
      w.addr = {a[31:2], 2'b00}; w.wdata = d; w.wmask = m;
      exp_q.push_back(w);
    end
  endtask

  // One cycle: retire last cycle's pop, drive inputs after negedge, let comb settle.
  task automatic tick(input logic resp, input logic r);
    @(negedge clk);
    if (popped) fq.delete(0);
    rst        = r;
    fifo_empty = (fq.size() == 0);
    fifo_out   = fifo_empty ? mem_pkt_t'('0) : fq[0];
    dmem_resp  = resp;
    #1;
    popped = fifo_ren;
  endtask

  // Monitor: completed writes against the scoreboard, and request hold while waiting.
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [3:0]  p_wmask = '0;
  logic        p_resp = 1'b0, p_rst = 1'b1;
  always @(negedge clk) begin
    wr_t e;
    #3;
    if (!rst) begin
      if (p_wmask != 4'b0000 && !p_resp && !p_rst) begin
        checks++;
        if (dmem_addr !== p_addr || dmem_wdata !== p_wdata || dmem_wmask !== p_wmask) begin
          errors++;
          $display("FAIL hold: got %h/%h/%h expected %h/%h/%h",
                   dmem_addr, dmem_wdata, dmem_wmask, p_addr, p_wdata, p_wmask);
        end
      end
      if (dmem_resp && dmem_wmask != 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got %h/%h/%h expected none",
                   dmem_addr, dmem_wdata, dmem_wmask);
        end else begin
          e = exp_q.pop_front();
          if (dmem_addr !== e.addr || dmem_wdata !== e.wdata || dmem_wmask !== e.wmask) begin
            errors++;
            $display("FAIL write: got %h/%h/%h expected %h/%h/%h",
                     dmem_addr, dmem_wdata, dmem_wmask, e.addr, e.wdata, e.wmask);
          end
        end
      end
    end
    p_addr = dmem_addr; p_wdata = dmem_wdata; p_wmask = dmem_wmask;
    p_resp = dmem_resp; p_rst = rst;
  end

  logic t4_resp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic t4_ren  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic t4_req  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int bad;
    mem_pkt_t tmp;
    rst = 1'b1; fifo_empty = 1'b1; fifo_out = '0; dmem_resp = 1'b0;

    // 1: reset, then idle with an empty FIFO
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      if (fifo_ren !== 1'b0 || dmem_wmask !== 4'b0000) bad++;
    end
    chk("t1_idle_quiet", 32'(bad), 32'd0);
    chk("t1_drained", st_drained_cnt, 32'd0);
    chk("t1_stall", st_stall_cnt, 32'd0);
    chk("t1_inflight", 32'(st_inflight), 32'd0);
    chk("t1_addr", dmem_addr, 32'd0);
    chk("t1_wdata", dmem_wdata, 32'd0);

    // 2: single store, response on the third request cycle
    push(32'h1000_0006, 32'hABCD_0000, 4'b1100, 4'b0000);
    tick(1'b0, 1'b0);
    chk("t2_ren_N", 32'(fifo_ren), 32'd1);
    chk("t2_wmask_N", 32'(dmem_wmask), 32'd0);
    tick(1'b0, 1'b0);
    chk("t2_addr_N1", dmem_addr, 32'h1000_0004);
    chk("t2_wmask_N1", 32'(dmem_wmask), 32'hC);
    chk("t2_inflight_N1", 32'(st_inflight), 32'd1);
    chk("t2_infl_addr_N1", st_inflight_addr, 32'h1000_0004);
    tick(1'b0, 1'b0);
    chk("t2_wmask_N2", 32'(dmem_wmask), 32'hC);
    tick(1'b1, 1'b0);
    chk("t2_wmask_N3", 32'(dmem_wmask), 32'hC);
    tick(1'b0, 1'b0);
    chk("t2_wmask_N4", 32'(dmem_wmask), 32'd0);
    chk("t2_inflight_N4", 32'(st_inflight), 32'd0);
    chk("t2_stall", st_stall_cnt, 32'd2);
    chk("t2_drained", st_drained_cnt, 32'd1);

    // 3: speculative head is held until its bmask clears
    push(32'h2000_0010, 32'h1122_3344, 4'b1111, 4'b0010);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      if (fifo_ren !== 1'b0) bad++;
    end
    chk("t3_no_pop_spec", 32'(bad), 32'd0);
    tmp = fq[0]; tmp.bmask = 4'b0000; fq[0] = tmp;
    tick(1'b0, 1'b0);
    chk("t3_pop_resolved", 32'(fifo_ren), 32'd1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("t3_drained", st_drained_cnt, 32'd2);
    chk("t3_stall", st_stall_cnt, 32'd3);

    // 4: three back-to-back stores, response the cycle after each request
    push(32'h3000_0000, 32'hDEAD_BEEF, 4'b1111, 4'b0000);
    push(32'h3000_0005, 32'h0000_5500, 4'b0010, 4'b0000);
    push(32'h3000_000B, 32'h7700_0000, 4'b1000, 4'b0000);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick(t4_resp[i], 1'b0);
      if (fifo_ren !== t4_ren[i]) bad++;
      if ((dmem_wmask != 4'b0000) !== t4_req[i]) bad++;
    end
    chk("t4_pop_req_pattern", 32'(bad), 32'd0);
    chk("t4_drained", st_drained_cnt, 32'd5);
    chk("t4_stall", st_stall_cnt, 32'd6);

    // 5: reset lands in WAIT together with the response
    push(32'h4000_0000, 32'hCAFE_F00D, 4'b1111, 4'b0000);
    push(32'h4000_0004, 32'h0102_0304, 4'b0011, 4'b0000);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    chk("t5_no_pop_in_rst", 32'(fifo_ren), 32'd0);
    tick(1'b0, 1'b1);
    chk("t5_rst_wmask", 32'(dmem_wmask), 32'd0);
    chk("t5_rst_addr", dmem_addr, 32'd0);
    chk("t5_rst_wdata", dmem_wdata, 32'd0);
    chk("t5_rst_inflight", 32'(st_inflight), 32'd0);
    chk("t5_rst_drained", st_drained_cnt, 32'd0);
    chk("t5_rst_stall", st_stall_cnt, 32'd0);
    chk("t5_rst_hold_ren", 32'(fifo_ren), 32'd0);
    exp_q.delete(0);
    tick(1'b0, 1'b0);
    chk("t5_pop_after_rst", 32'(fifo_ren), 32'd1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("t5_drained", st_drained_cnt, 32'd1);

    // 6: empty-mask store retires without a request
    push(32'h5000_0000, 32'hFFFF_FFFF, 4'b0000, 4'b0000);
    push(32'h5000_0008, 32'h0000_00AA, 4'b0001, 4'b0000);
    tick(1'b0, 1'b0);
    chk("t6_pop_degenerate", 32'(fifo_ren), 32'd1);
    tick(1'b0, 1'b0);
    chk("t6_no_request", 32'(dmem_wmask), 32'd0);
    chk("t6_no_inflight", 32'(st_inflight), 32'd0);
    chk("t6_no_pop_in_req", 32'(fifo_ren), 32'd0);
    tick(1'b0, 1'b0);
    chk("t6_drained_deg", st_drained_cnt, 32'd2);
    chk("t6_idle_pops_next", 32'(fifo_ren), 32'd1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("t6_drained", st_drained_cnt, 32'd3);

    // late response while idle is ignored
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("idle_resp_ignored", st_drained_cnt, 32'd3);

    tick(1'b0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
